// File: rtl/i2c_resp_pkg.sv
// Shared types and constants for the I2C EEPROM responder: FSM states,
// bit-counter sizing and the bus levels that mean ACK / NACK.
package i2c_resp_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WADDR,
    WADDR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } resp_state_e;

  localparam int BIT_CNT_W = 4;

  // Bit-counter landmarks: last data bit, ACK slot, ACK slot with SDA driven.
  localparam logic [BIT_CNT_W-1:0] BIT_LAST    = 4'd7;
  localparam logic [BIT_CNT_W-1:0] BIT_ACK     = 4'd8;
  localparam logic [BIT_CNT_W-1:0] BIT_ACK_HLD = 4'd9;

  localparam logic ACK_LVL  = 1'b0;
  localparam logic NACK_LVL = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA onto the system clock and derives SCL edges plus
// START/STOP conditions from the synchronised copies.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl;
  logic                   scl_q;
  logic                   sda_q;

  // Flops reset to 1 so an idle, pulled-up bus produces no edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // value, which is what makes this a shift chain and not one wire.
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q    <= scl_sync[SYNC_STAGES-1];
      sda_q    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl = scl_sync[SYNC_STAGES-1];
  assign sda = sda_sync[SYNC_STAGES-1];

  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;

  // START/STOP need SCL high in both samples; SDA moving together with an
  // SCL edge is ordinary data.
  assign start = scl & scl_q & sda_q & ~sda;
  assign stop  = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/i2c_eeprom_responder.sv
// I2C target emulating a 24Cxx-style EEPROM with a single address byte.
// SDA is open-drain: sda_oe=1 pulls the line low, 0 releases it.
module i2c_eeprom_responder
  import i2c_resp_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         MEM_AW      = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              axi_aclk,
  input  logic              axi_areset,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              busy,
  output logic              wr_pulse,
  output logic [MEM_AW-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam int DEPTH = 2 ** MEM_AW;

  logic sda;
  logic scl_rise;
  logic scl_fall;
  logic bus_start;
  logic bus_stop;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_sync (
    .clk     (axi_aclk),
    .rst     (axi_areset),
    .scl_i   (scl_i),
    .sda_i   (sda_i),
    .sda     (sda),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .start   (bus_start),
    .stop    (bus_stop)
  );

  resp_state_e            state, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_d;
  logic [7:0]             shreg, shreg_d;
  logic [7:0]             tx, tx_d;
  logic [MEM_AW-1:0]      ptr, ptr_d;
  logic                   rw, rw_d;
  logic                   sda_oe_d;
  logic                   busy_d;
  logic                   mem_we;
  logic [7:0]             rx_byte;
  logic                   byte_done;
  logic [7:0]             mem_rd;

  // Power-up contents of an erased EEPROM.
  logic [7:0] mem [DEPTH] = '{default: 8'hFF};

  // Byte as it stands once the SDA bit of the current rise is shifted in.
  assign rx_byte   = {shreg[6:0], sda};
  assign byte_done = scl_rise && (bit_cnt == BIT_LAST);
  assign mem_rd    = mem[ptr];

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d   = state;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    tx_d      = tx;
    ptr_d     = ptr;
    rw_d      = rw;
    sda_oe_d  = sda_oe;
    busy_d    = busy;
    mem_we    = 1'b0;

    if (bus_stop) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (bus_start) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      if (scl_rise) shreg_d = rx_byte;

      case (state)
        ADDR, WADDR, WDATA: begin
          if (scl_rise) bit_cnt_d = bit_cnt + 1'b1;
          if (byte_done) begin
            if (state == ADDR) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = rx_byte[0];
              end else begin
                state_d = IGNORE;
                busy_d  = 1'b0;
              end
            end else if (state == WADDR) begin
              ptr_d   = rx_byte[MEM_AW-1:0];
              state_d = WADDR_ACK;
            end else begin
              mem_we  = 1'b1;
              ptr_d   = ptr + 1'b1;
              state_d = WDATA_ACK;
            end
          end
        end

        // Drive ACK from the 8th fall to the 9th fall, then hand over.
        ADDR_ACK, WADDR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (bit_cnt == BIT_ACK) begin
              sda_oe_d  = (ACK_LVL == 1'b0);
              bit_cnt_d = BIT_ACK_HLD;
            end else begin
              bit_cnt_d = '0;
              sda_oe_d  = 1'b0;
              if (state == ADDR_ACK && rw) begin
                tx_d     = mem_rd;
                sda_oe_d = ~mem_rd[7];
                state_d  = RDATA;
              end else begin
                state_d = (state == ADDR_ACK) ? WADDR : WDATA;
              end
            end
          end
        end

        RDATA: begin
          if (scl_rise && bit_cnt != BIT_ACK) bit_cnt_d = bit_cnt + 1'b1;
          if (scl_fall) begin
            if (bit_cnt == BIT_ACK) begin
              sda_oe_d = 1'b0;
              state_d  = RDATA_ACK;
            end else begin
              tx_d     = {tx[6:0], 1'b0};
              sda_oe_d = ~tx[6];
            end
          end
        end

        RDATA_ACK: begin
          if (scl_rise && bit_cnt == BIT_ACK) begin
            if (sda == NACK_LVL) begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end else begin
              ptr_d     = ptr + 1'b1;
              bit_cnt_d = BIT_ACK_HLD;
            end
          end else if (scl_fall && bit_cnt == BIT_ACK_HLD) begin
            tx_d      = mem_rd;
            sda_oe_d  = ~mem_rd[7];
            bit_cnt_d = '0;
            state_d   = RDATA;
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= '0;
      ptr      <= '0;
      rw       <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_pulse <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state    <= state_d;
      bit_cnt  <= bit_cnt_d;
      shreg    <= shreg_d;
      tx       <= tx_d;
      ptr      <= ptr_d;
      rw       <= rw_d;
      sda_oe   <= sda_oe_d;
      busy     <= busy_d;
      wr_pulse <= mem_we;
      if (mem_we) begin
        wr_addr <= ptr;
        wr_data <= rx_byte;
      end
    end
  end

  // NOTE: the array has no reset branch on purpose; contents survive
  // reset and the array can map onto RAM primitives.
  always_ff @(posedge axi_aclk) begin
    if (mem_we) mem[ptr] <= rx_byte;
  end

endmodule

// File: tb/tb_i2c_eeprom_responder.sv
// Bench acting as I2C master against the EEPROM responder, checked against
// an array-plus-pointer model of the EEPROM.
module tb_i2c_eeprom_responder;

  localparam int Q = 100;  // quarter SCL period (10 system clocks)

  logic       axi_aclk;
  logic       axi_areset;
  logic       scl_i;
  logic       sda_m;
  logic       sda_i;
  logic       sda_oe;
  logic       busy;
  logic       wr_pulse;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  model_mem [256];
  logic [7:0]  model_ptr;
  logic [15:0] wrq [$];
  logic [7:0]  data_q [$];
  int          oe_cnt = 0;

  assign sda_i = sda_m & ~sda_oe;

  i2c_eeprom_responder #(
    .DEV_ADDR   (7'h50),
    .MEM_AW     (8),
    .SYNC_STAGES(2)
  ) dut (
    .axi_aclk  (axi_aclk),
    .axi_areset(axi_areset),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_oe    (sda_oe),
    .busy      (busy),
    .wr_pulse  (wr_pulse),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  always @(negedge axi_aclk) begin
    if (wr_pulse) wrq.push_back({wr_addr, wr_data});
    if (sda_oe) oe_cnt++;
  end

  task automatic bit_out(input logic b, output logic smp);
    sda_m = b;
    #Q scl_i = 1'b1;
    #Q smp = sda_i;
    #Q scl_i = 1'b0;
    #Q;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    #Q scl_i = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl_i = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    #Q scl_i = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
    #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_out(b[i], s);
    bit_out(1'b1, ack);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_out(1'b1, s);
      d[i] = s;
    end
    bit_out(master_ack, s);
  endtask

  // Writes data_q starting at a; checks every ACK and the wr_pulse log.
  task automatic write_txn(input string tag, input logic [7:0] a);
    logic        ack;
    int          base;
    logic [15:0] exp;
    base = wrq.size();
    i2c_start();
    send_byte(8'hA0, ack);
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL %s dev_ack: got %b want 0", tag, ack); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy: got %b want 1", tag, busy); end
    send_byte(a, ack);
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL %s waddr_ack: got %b want 0", tag, ack); end
    model_ptr = a;
    foreach (data_q[i]) begin
      send_byte(data_q[i], ack);
      n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL %s data_ack[%0d]: got %b want 0", tag, i, ack); end
    end
    i2c_stop();
    n_vec++;
    if (wrq.size() - base != data_q.size()) begin
      n_err++; $display("FAIL %s wr_count: got %0d want %0d", tag, wrq.size() - base, data_q.size());
    end
    foreach (data_q[i]) begin
      exp = {model_ptr, data_q[i]};
      n_vec++;
      if (base + i >= wrq.size() || wrq[base + i] !== exp) begin
        n_err++;
        $display("FAIL %s wr[%0d]: got %h want %h", tag, i,
                 (base + i < wrq.size()) ? wrq[base + i] : 16'hxxxx, exp);
      end
      model_mem[model_ptr] = data_q[i];
      model_ptr++;
    end
  endtask

  // Reads n bytes (ACK all but the last); with set_addr a dummy write sets ptr.
  task automatic read_txn(input string tag, input logic set_addr, input logic [7:0] a, input int n);
    logic       ack;
    logic [7:0] d;
    i2c_start();
    if (set_addr) begin
      send_byte(8'hA0, ack);
      n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL %s dev_ack: got %b want 0", tag, ack); end
      send_byte(a, ack);
      n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL %s waddr_ack: got %b want 0", tag, ack); end
      model_ptr = a;
      i2c_start();
    end
    send_byte(8'hA1, ack);
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL %s rd_ack: got %b want 0", tag, ack); end
    for (int i = 0; i < n; i++) begin
      read_byte((i == n - 1) ? 1'b1 : 1'b0, d);
      n_vec++;
      if (d !== model_mem[model_ptr]) begin
        n_err++; $display("FAIL %s data[%0d]@%h: got %h want %h", tag, i, model_ptr, d, model_mem[model_ptr]);
      end
      if (i != n - 1) model_ptr++;
    end
    n_vec++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL %s oe_after_nack: got %b want 0", tag, sda_oe); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy_after_nack: got %b want 0", tag, busy); end
    i2c_stop();
  endtask

  task automatic test_reset();
    axi_areset = 1'b1;
    repeat (5) @(posedge axi_aclk);
    #1;
    n_vec++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL reset sda_oe: got %b want 0", sda_oe); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", busy); end
    n_vec++; if (wr_pulse !== 1'b0) begin n_err++; $display("FAIL reset wr_pulse: got %b want 0", wr_pulse); end
    n_vec++; if (wr_addr !== 8'h00) begin n_err++; $display("FAIL reset wr_addr: got %h want 00", wr_addr); end
    n_vec++; if (wr_data !== 8'h00) begin n_err++; $display("FAIL reset wr_data: got %h want 00", wr_data); end
    axi_areset = 1'b0;
    model_ptr  = 8'h00;
    #(4 * Q);
  endtask

  task automatic test_write3();
    data_q = '{8'h11, 8'h22, 8'h33};
    write_txn("write3", 8'h10);
  endtask

  task automatic test_random_read();
    read_txn("rand_read", 1'b1, 8'h10, 3);
  endtask

  task automatic test_addr_miss();
    logic ack;
    int   oe0;
    int   wr0;
    oe0 = oe_cnt;
    wr0 = wrq.size();
    i2c_start();
    send_byte(8'hA2, ack);
    n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL miss ack: got %b want 1", ack); end
    send_byte(8'($urandom), ack);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL miss busy: got %b want 0", busy); end
    i2c_stop();
    n_vec++; if (oe_cnt != oe0) begin n_err++; $display("FAIL miss sda_oe_cycles: got %0d want 0", oe_cnt - oe0); end
    n_vec++; if (wrq.size() != wr0) begin n_err++; $display("FAIL miss wr_count: got %0d want 0", wrq.size() - wr0); end
  endtask

  task automatic test_wrap();
    data_q = '{8'hAB, 8'hCD};
    write_txn("wrap", 8'hFF);
    read_txn("wrap_cur_read", 1'b0, 8'h00, 1);
  endtask

  task automatic test_mid_stop();
    logic ack;
    logic s;
    int   wr0;
    wr0 = wrq.size();
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h40, ack);
    model_ptr = 8'h40;
    for (int i = 0; i < 4; i++) bit_out(1'($urandom), s);
    i2c_stop();
    n_vec++; if (wrq.size() != wr0) begin n_err++; $display("FAIL mid_stop wr_count: got %0d want 0", wrq.size() - wr0); end
    n_vec++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL mid_stop sda_oe: got %b want 0", sda_oe); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_stop busy: got %b want 0", busy); end
    data_q = '{8'($urandom), 8'($urandom)};
    write_txn("after_stop", 8'h41);
  endtask

  task automatic test_async_reset();
    logic ack;
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h10, ack);
    i2c_start();
    send_byte(8'hA1, ack);
    n_vec++;
    if (sda_oe !== ~model_mem[8'h10][7]) begin
      n_err++; $display("FAIL arst pre_drive: got %b want %b", sda_oe, ~model_mem[8'h10][7]);
    end
    #(Q / 2);
    axi_areset = 1'b1;
    #1;
    n_vec++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL arst sda_oe: got %b want 0", sda_oe); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst busy: got %b want 0", busy); end
    scl_i = 1'b1;
    #Q sda_m = 1'b1;
    #Q axi_areset = 1'b0;
    model_ptr = 8'h00;
    #(2 * Q);
    data_q = '{8'h5A};
    write_txn("post_rst_wr", 8'h20);
    read_txn("post_rst_rd", 1'b1, 8'h20, 1);
  endtask

  task automatic test_random();
    int kind;
    int n;
    for (int it = 0; it < 8; it++) begin
      kind = $urandom_range(0, 2);
      n    = $urandom_range(1, 4);
      if (kind == 0) begin
        data_q.delete();
        for (int i = 0; i < n; i++) data_q.push_back(8'($urandom));
        write_txn("rnd_wr", 8'($urandom));
      end else if (kind == 1) begin
        read_txn("rnd_rd", 1'b1, 8'($urandom), n);
      end else begin
        read_txn("rnd_cur", 1'b0, 8'h00, n);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = 8'hFF;
    axi_areset = 1'b1;
    scl_i      = 1'b1;
    sda_m      = 1'b1;
    model_ptr  = 8'h00;
    test_reset();
    test_write3();
    test_random_read();
    test_addr_miss();
    test_wrap();
    test_mid_stop();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_responder.md
Name: i2c_eeprom_responder

Overview:
- I2C target (responder) modelling a 24Cxx-style single-byte-address EEPROM, built as the other end of the SoC I2C master on i2c_scl/i2c_sda.
- Replaces the missing EEPROM on the board bench, so master transfers get ACKs instead of timing out.
- Oversamples SCL/SDA on the system clock.
- Drives SDA open-drain only: low or released.

Parameters:
- DEV_ADDR, 7'h50, 7-bit target address matched after START.
- MEM_AW, 8, internal memory address width; depth 2**MEM_AW bytes (MEM_AW ≤ 8).
- SYNC_STAGES, 2, synchroniser flops on scl_i/sda_i (≥2).

Ports:
- axi_aclk  in  1  system clock; must be ≥16× the SCL rate.
- axi_areset  in  1  asynchronous reset, active-high.
- scl_i  in  1  SCL as seen on the wire (pulled-up).
- sda_i  in  1  SDA as seen on the wire.
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- busy  out  1  high between an address-matched START and the following STOP/NACK.
- wr_pulse  out  1  one-cycle strobe on each memory byte write.
- wr_addr  out  MEM_AW  address of the write on wr_pulse.
- wr_data  out  8  data of the write on wr_pulse.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - sda_oe=0, busy=0, wr_pulse=0, wr_addr=0, wr_data=0, state=IDLE, address pointer=0, bit counter=0.
  - Memory contents are not cleared; they initialise to 8'hFF at time zero.
- Sampling:
  - scl_i and sda_i pass through SYNC_STAGES flops; edges are detected on the synced copies.
  - SCL rise: sample SDA into the shift register (MSB first).
  - SCL fall: update sda_oe, registered, one cycle after fall detection.
- START is SDA falling while SCL is high. Enter ADDR, clear the bit counter, sda_oe=0. Valid from any state (repeated START).
- STOP is SDA rising while SCL is high. Enter IDLE, sda_oe=0, busy=0. Valid from any state.
- States:
  - IDLE: wait for START.
  - ADDR: after the 8th rise, compare bits[7:1] with DEV_ADDR.
    - Match: go to ADDR_ACK, set busy=1, latch R/W.
    - Mismatch: go to IGNORE with no ACK.
  - ADDR_ACK: sda_oe=1 from the 8th SCL fall to the 9th SCL fall.
    - Then W → WADDR.
    - Then R → RDATA, loading mem[ptr] and driving its bit7 at that same fall.
  - WADDR: after 8 bits, ptr = byte[MEM_AW-1:0], then ACK and go to WDATA.
  - WDATA: after 8 bits, write mem[ptr], pulse wr_pulse, ptr = ptr+1 (wraps at 2**MEM_AW-1 → 0), then ACK and stay in WDATA.
  - RDATA: on each SCL fall, sda_oe = ~current bit. After the 8th bit, release SDA at the next fall and go to RDATA_ACK.
  - RDATA_ACK: sample the master ACK on the 9th rise.
    - SDA=0: ptr = ptr+1 (wrap), load the next byte, and drive its bit7 at the 9th fall; back to RDATA.
    - SDA=1 (NACK): go to IGNORE, busy=0.
  - IGNORE: SDA released; wait for START or STOP.
- Pointer behaviour:
  - The pointer persists across transactions (current-address read).
  - A read issued with no preceding WADDR reads from the retained ptr.
- SDA/SCL both changing in the same sampled cycle: treated as data, no START/STOP.
- A STOP in the middle of a WDATA byte discards the partial byte and does not pulse wr_pulse.
- wr_pulse occurs on the cycle after the 8th-bit SCL rise is detected.

Decomposition:
- Package i2c_resp_pkg holds:
  - state enum (IDLE, ADDR, ADDR_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE);
  - the bit-count width constant;
  - the ACK/NACK level constants.
- Sub-module i2c_bus_sync: synchroniser plus scl_rise/scl_fall/start/stop detection; reused later by the bench for a bus monitor.
- Memory is an inferred array inside the top module.

Test Plan:
- Write 3 bytes: START, 0xA0, 0x10, 0x11, 0x22, 0x33, STOP → ACK on all 5 bytes; wr_pulse ×3 with (0x10,0x11), (0x11,0x22), (0x12,0x33).
- Random read: START, 0xA0, 0x10, repeated START, 0xA1, read 3 bytes (ACK, ACK, NACK), STOP → data 0x11, 0x22, 0x33; sda_oe=0 after NACK; busy falls.
- Address miss: START, 0xA2 → no ACK (SDA high at the 9th rise), sda_oe stays 0 through the whole transfer, busy=0.
- Wrap: write ptr 0xFF with data 0xAB, 0xCD → wr_addr 0xFF then 0x00. Current-address read then returns mem[0x01]=0xFF.
- Mid-byte STOP: STOP after 4 data bits of WDATA → no wr_pulse, IDLE, sda_oe=0. The next transaction ACKs normally.
- Async reset asserted during RDATA while driving 0 → sda_oe=0 immediately (same time step), busy=0. After release, a write then readback of 0x5A at 0x20 succeeds.
